// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice reused LSB-first over WIDTH clocks.
// Optional subtract port `sub` is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] rs_q;
    logic             cy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             busy_q;
    logic             done_q;

    logic             fs_d;
    logic             fc_d;
    logic [WIDTH-1:0] rsNext_d;
    logic             lastBit_d;
    logic             acceptStart_d;
    logic [WIDTH-1:0] bLoad_d;
    logic             cyLoad_d;

    // Full-adder slice on the current LSBs, plus operand preparation for a new start.
    always_comb begin
        fs_d          = ra_q[0] ^ rb_q[0] ^ cy_q;
        fc_d          = (ra_q[0] & rb_q[0]) | (rb_q[0] & cy_q) | (cy_q & ra_q[0]);
        rsNext_d      = {fs_d, rs_q[WIDTH-1:1]};
        lastBit_d     = (cnt_q == CW'(WIDTH - 1));
        acceptStart_d = start && ((state_q == IDLE) || (state_q == DONE));
`ifdef SERIAL_ADDER_SUB_EN
        // Subtraction is a + ~b + 1, so co=1 means no borrow.
        bLoad_d       = sub ? ~b : b;
        cyLoad_d      = sub ? 1'b1 : ci;
`else
        bLoad_d       = b;
        cyLoad_d      = ci;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (acceptStart_d) begin
            state_q <= RUN;
            ra_q    <= a;
            rb_q    <= bLoad_d;
            cy_q    <= cyLoad_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    ra_q  <= ra_q >> 1;
                    rb_q  <= rb_q >> 1;
                    rs_q  <= rsNext_d;
                    cy_q  <= fc_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Results are published only once, so s/co never show partial sums.
                    if (lastBit_d) begin
                        s_q     <= rsNext_d;
                        co_q    <= fc_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s    = s_q;
    assign co   = co_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ci = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub = 1'b0;
`endif
    logic [WIDTH-1:0] s;
    logic             co;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .s     (s),
        .co    (co),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [7:0] expS, input logic expCo,
                            input logic expBusy, input logic expDone);
        checkOutput({tag, "_s"}, 32'(s), 32'(expS));
        checkOutput({tag, "_co"}, 32'(co), 32'(expCo));
        checkOutput({tag, "_busy"}, 32'(busy), 32'(expBusy));
        checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
    endtask

    // Pulses start for one edge (E0) and returns at the negedge after E0,
    // with operands scrambled to show they are not re-sampled.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic civ);
        @(negedge clk);
        a = av;
        b = bv;
        ci = civ;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av;
        b = 8'h5B;
        ci = ~civ;
    endtask

    // Walks the WIDTH run cycles, optionally pulsing start with other operands
    // at iterations g1/g2, and returns at the negedge after E_WIDTH.
    task automatic waitResult(input string tag, input logic [7:0] prevS, input logic prevCo,
                              input logic [7:0] expS, input logic expCo,
                              input int g1, input int g2,
                              input logic [7:0] ga, input logic [7:0] gb, input logic keepStart);
        for (int i = 0; i < WIDTH; i++) begin
            checkAll($sformatf("%s_run%0d", tag, i), prevS, prevCo, 1'b1, 1'b0);
            if (i == g1 || i == g2) begin
                start = 1'b1;
                a = ga;
                b = gb;
                ci = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        if (!keepStart) start = 1'b0;
        checkAll({tag, "_done"}, expS, expCo, 1'b0, 1'b1);
    endtask

    task automatic checkFall(input string tag, input logic [7:0] expS, input logic expCo);
        @(negedge clk);
        checkAll({tag, "_after"}, expS, expCo, 1'b0, 1'b0);
    endtask

    initial begin
        $display("[TB] serial_adder directed test, WIDTH=%0d", WIDTH);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkAll("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        applyStimulus(8'h00, 8'h00, 1'b0);
        waitResult("zero", 8'h00, 1'b0, 8'h00, 1'b0, -1, -1, 8'h00, 8'h00, 1'b0);
        checkFall("zero", 8'h00, 1'b0);

        applyStimulus(8'hFF, 8'h01, 1'b0);
        waitResult("ff_01", 8'h00, 1'b0, 8'h00, 1'b1, -1, -1, 8'h00, 8'h00, 1'b0);
        checkFall("ff_01", 8'h00, 1'b1);

        applyStimulus(8'hA5, 8'h5A, 1'b1);
        waitResult("a5_5a", 8'h00, 1'b1, 8'h00, 1'b1, -1, -1, 8'h00, 8'h00, 1'b0);
        checkFall("a5_5a", 8'h00, 1'b1);

        // Starts during RUN must be ignored.
        applyStimulus(8'h3C, 8'h42, 1'b0);
        waitResult("ignore", 8'h00, 1'b1, 8'h7E, 1'b0, 3, 5, 8'hFF, 8'hFF, 1'b0);
        checkFall("ignore", 8'h7E, 1'b0);

        // Reset mid-run: clears outputs and no done strobe follows.
        applyStimulus(8'h12, 8'h34, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkAll($sformatf("abort_run%0d", i), 8'h7E, 1'b0, 1'b1, 1'b0);
            if (i == 3) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        checkAll("abort_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("abort_nodone%0d", i), 32'(done), 32'd0);
        end

        applyStimulus(8'hFF, 8'h01, 1'b0);
        waitResult("fresh", 8'h00, 1'b0, 8'h00, 1'b1, -1, -1, 8'h00, 8'h00, 1'b0);
        checkFall("fresh", 8'h00, 1'b1);

        // Back-to-back: start held from E7 through the done cycle.
        applyStimulus(8'h3C, 8'h42, 1'b0);
        waitResult("b2b_first", 8'h00, 1'b1, 8'h7E, 1'b0, WIDTH - 1, -1, 8'h12, 8'h34, 1'b1);
        ci = 1'b0;
        @(negedge clk);
        start = 1'b0;
        waitResult("b2b_second", 8'h7E, 1'b0, 8'h46, 1'b0, -1, -1, 8'h00, 8'h00, 1'b0);
        checkFall("b2b_second", 8'h46, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        applyStimulus(8'h10, 8'h01, 1'b0);
        waitResult("sub_10_01", 8'h46, 1'b0, 8'h0F, 1'b1, -1, -1, 8'h00, 8'h00, 1'b0);
        checkFall("sub_10_01", 8'h0F, 1'b1);
        applyStimulus(8'h00, 8'h01, 1'b0);
        waitResult("sub_00_01", 8'h0F, 1'b1, 8'hFF, 1'b0, -1, -1, 8'h00, 8'h00, 1'b0);
        checkFall("sub_00_01", 8'hFF, 1'b0);
        sub = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
